// File: rtl/cle_sdwr_pkg.sv
// cle_sdwr_pkg: shared types and constants for the CLE serial-data write transmitter.
//   tx_state_e  : frame state machine encoding
//   REG_*       : register offsets within the CLE I/O window (ba[7:4])
//   STAT_*      : bit positions in the STATUS register
//   CTRL_*      : bit positions in the CTRL register
//   LFSR_TAPS   : scrambler tap mask over q[6:1] (q1 ^ q4 ^ q6)
package cle_sdwr_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_e;

    localparam logic [3:0] REG_DATA   = 4'h0;
    localparam logic [3:0] REG_CTRL   = 4'h1;
    localparam logic [3:0] REG_STATUS = 4'h2;

    localparam int unsigned STAT_TX_BUSY = 0;
    localparam int unsigned STAT_FULL    = 1;
    localparam int unsigned STAT_IRQ_EN  = 2;
    localparam int unsigned STAT_OVERRUN = 3;

    localparam int unsigned CTRL_CLR_OVR = 0;
    localparam int unsigned CTRL_ABORT   = 1;
    localparam int unsigned CTRL_IRQ_EN  = 2;

    localparam logic [6:1] LFSR_TAPS = 6'b101001;

    function automatic logic lfsr_tap(input logic [6:1] q);
        return ^(q & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/cle_sdwr_lfsr.sv
// cle_sdwr_lfsr: 6-bit scrambler LFSR, q[6:1], feedback q1 ^ q4 ^ q6 shifted into q1.
//   clk, rst_n : clock, async active-low reset (state returns to SEED)
//   load_i     : reload SEED (wins over step_i)
//   step_i     : advance one position
//   tap_o      : current tap output, XORed into the outgoing data bit
module cle_sdwr_lfsr
    import cle_sdwr_pkg::*;
#(
    parameter logic [5:0] SEED = 6'h3F
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic step_i,
    output logic tap_o
);

    logic [6:1] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = SEED;
        end else if (step_i) begin
            q_d = {q_q[5:1], lfsr_tap(q_q)};
        end
    end

    assign tap_o = lfsr_tap(q_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= SEED;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/cle_sdwr_tx.sv
// cle_sdwr_tx: CLE serial-data write transmitter. A host byte written to DATA is framed as
// start(0), 8 data bits LSB first, even parity, stop(1), each bit DIV clks, on sd_wr.
// Optional scrambling of the data bits is enabled by defining CLE_SCRAMBLE_EN.
//   clk, rst_n      : clock, async active-low reset
//   sser_n, ba, br_w: window select (active low), address ba[13:4], direction (1 = read)
//   bd_in           : write data; bd_out/bd_oe: STATUS read data and its enable (combinational)
//   sd_wr           : serial out, idles high; tx_busy: frame in progress
//   irq_n           : active-low interrupt while irq_en and the holding register is empty
module cle_sdwr_tx
    import cle_sdwr_pkg::*;
#(
    parameter int unsigned DIV       = 16,
    parameter logic [5:0]  LFSR_SEED = 6'h3F
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sser_n,
    input  logic [9:0] ba,
    input  logic       br_w,
    input  logic [7:0] bd_in,
    output logic [7:0] bd_out,
    output logic       bd_oe,
    output logic       sd_wr,
    output logic       tx_busy,
    output logic       irq_n
);

    localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;

    if (DIV < 2 || LFSR_SEED == 6'h00) begin : g_bad_cfg
        $error("cle_sdwr_tx: DIV must be >= 2 and LFSR_SEED nonzero");
    end

    tx_state_e      state_q, state_d;
    logic [DivW-1:0] div_q, div_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     shift_q, shift_d;
    logic [7:0]     hold_q, hold_d;
    logic           full_q, full_d;
    logic           par_q, par_d;
    logic           ovr_q, ovr_d;
    logic           irq_en_q, irq_en_d;
    logic           sd_wr_q, sd_wr_d;
    logic           tx_busy_q, tx_busy_d;
    logic           irq_n_q, irq_n_d;

    logic       win, wr_data, wr_ctrl, div_term, load, data_bit;
    logic [7:0] status;
    logic       unused_ba;

    // ba[11:8] does not take part in the decode.
    assign unused_ba = ^ba[7:4];

    assign win      = ~sser_n & ~ba[9] & ba[8];
    assign wr_data  = win & ~br_w & (ba[3:0] == REG_DATA);
    assign wr_ctrl  = win & ~br_w & (ba[3:0] == REG_CTRL);
    assign bd_oe    = win &  br_w & (ba[3:0] == REG_STATUS);
    assign div_term = (div_q == DivW'(DIV - 1));

`ifdef CLE_SCRAMBLE_EN
    logic scr_tap, lfsr_load, lfsr_step;

    // Reseeded throughout START so every frame scrambles from the same point.
    assign lfsr_load = (state_q == StStart);
    assign lfsr_step = (state_q == StData) & div_term;

    cle_sdwr_lfsr #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load_i(lfsr_load),
        .step_i(lfsr_step),
        .tap_o (scr_tap)
    );

    assign data_bit = shift_q[0] ^ scr_tap;
`else
    assign data_bit = shift_q[0];
`endif

    always_comb begin
        status               = 8'h00;
        status[STAT_TX_BUSY] = tx_busy_q;
        status[STAT_FULL]    = full_q;
        status[STAT_IRQ_EN]  = irq_en_q;
        status[STAT_OVERRUN] = ovr_q;
    end

    assign bd_out = bd_oe ? status : 8'h00;

    always_comb begin
        state_d  = state_q;
        div_d    = (state_q == StIdle) ? '0 : (div_term ? '0 : div_q + 1'b1);
        bit_d    = bit_q;
        shift_d  = shift_q;
        hold_d   = hold_q;
        full_d   = full_q;
        par_d    = par_q;
        ovr_d    = ovr_q;
        irq_en_d = irq_en_q;
        sd_wr_d  = 1'b1;
        load     = 1'b0;

        // sd_wr_d reflects the current state, so the line lags the state by one clk.
        unique case (state_q)
            StIdle: begin
                load = full_q;
            end
            StStart: begin
                sd_wr_d = 1'b0;
                if (div_term) begin
                    state_d = StData;
                end
            end
            StData: begin
                sd_wr_d = data_bit;
                if (div_term) begin
                    shift_d = shift_q >> 1;
                    par_d   = par_q ^ data_bit;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = StParity;
                    end
                end
            end
            StParity: begin
                sd_wr_d = par_q;
                if (div_term) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (div_term) begin
                    load    = full_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            shift_d = hold_q;
            full_d  = 1'b0;
            div_d   = '0;
            bit_d   = 3'd0;
            par_d   = 1'b0;
            state_d = StStart;
        end

        // A write landing on the same edge as a drain is accepted.
        if (wr_data) begin
            if (full_q && !load) begin
                ovr_d = 1'b1;
            end else begin
                hold_d = bd_in;
                full_d = 1'b1;
            end
        end

        if (wr_ctrl) begin
            if (bd_in[CTRL_CLR_OVR]) begin
                ovr_d = 1'b0;
            end
            if (bd_in[CTRL_IRQ_EN]) begin
                irq_en_d = 1'b1;
            end
            if (bd_in[CTRL_ABORT]) begin
                state_d = StIdle;
                full_d  = 1'b0;
                div_d   = '0;
                sd_wr_d = 1'b1;
            end
        end

        tx_busy_d = (state_d != StIdle);
        irq_n_d   = ~(irq_en_d & ~full_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            div_q     <= '0;
            bit_q     <= 3'd0;
            shift_q   <= 8'h00;
            hold_q    <= 8'h00;
            full_q    <= 1'b0;
            par_q     <= 1'b0;
            ovr_q     <= 1'b0;
            irq_en_q  <= 1'b0;
            sd_wr_q   <= 1'b1;
            tx_busy_q <= 1'b0;
            irq_n_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            hold_q    <= hold_d;
            full_q    <= full_d;
            par_q     <= par_d;
            ovr_q     <= ovr_d;
            irq_en_q  <= irq_en_d;
            sd_wr_q   <= sd_wr_d;
            tx_busy_q <= tx_busy_d;
            irq_n_q   <= irq_n_d;
        end
    end

    assign sd_wr   = sd_wr_q;
    assign tx_busy = tx_busy_q;
    assign irq_n   = irq_n_q;

endmodule

// File: tb/tb_cle_sdwr_tx.sv
// tb_cle_sdwr_tx: directed bench for cle_sdwr_tx at DIV=4. A decode vector table plus
// hand-written sequences for framing, back-to-back, overrun, abort and async reset.
module tb_cle_sdwr_tx;
    import cle_sdwr_pkg::*;

    localparam int unsigned DIV  = 4;
    localparam logic [5:0]  SEED = 6'h3F;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sser_n;
    logic [9:0] ba;
    logic       br_w;
    logic [7:0] bd_in;
    logic [7:0] bd_out;
    logic       bd_oe;
    logic       sd_wr;
    logic       tx_busy;
    logic       irq_n;

    int         n_vec = 0;
    int         n_bad = 0;
    int         busy_cnt;
    logic [10:0] rx;

    typedef struct {
        logic       sser_n;
        logic [9:0] ba;
        logic       br_w;
        logic [7:0] bd;
        logic       exp_oe;
        logic [7:0] exp_stat;
    } dec_vec_t;

    dec_vec_t dv[7];

    cle_sdwr_tx #(
        .DIV      (DIV),
        .LFSR_SEED(SEED)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sser_n (sser_n),
        .ba     (ba),
        .br_w   (br_w),
        .bd_in  (bd_in),
        .bd_out (bd_out),
        .bd_oe  (bd_oe),
        .sd_wr  (sd_wr),
        .tx_busy(tx_busy),
        .irq_n  (irq_n)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] addr(input logic b13, input logic b12, input logic [3:0] off);
        return {b13, b12, 4'b0000, off};
    endfunction

    // Reference frame: index 0 = start, 1..8 = data LSB first, 9 = parity, 10 = stop.
    function automatic logic [10:0] make_frame(input logic [7:0] b);
        logic [10:0] f;
        logic [6:1]  m;
        logic        d, tap, par;
        m   = SEED;
        par = 1'b0;
        f   = '0;
        for (int i = 0; i < 8; i++) begin
            tap = m[1] ^ m[4] ^ m[6];
`ifdef CLE_SCRAMBLE_EN
            d = b[i] ^ tap;
`else
            d = b[i];
`endif
            m = {m[5:1], tap};
            par = par ^ d;
            f[1+i] = d;
        end
        f[0]  = 1'b0;
        f[9]  = par;
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h at %0t", what, act, exp, $time);
        end
    endtask

    task automatic bus_idle();
        sser_n = 1'b1;
        ba     = 10'h000;
        br_w   = 1'b1;
        bd_in  = 8'h00;
    endtask

    // Returns #1 after the write edge.
    task automatic bus_write(input logic [3:0] off, input logic [7:0] d);
        @(negedge clk);
        sser_n = 1'b0;
        ba     = addr(1'b0, 1'b1, off);
        br_w   = 1'b0;
        bd_in  = d;
        @(posedge clk);
        #1;
        bus_idle();
    endtask

    task automatic read_status(output logic [7:0] d, output logic oe);
        sser_n = 1'b0;
        ba     = addr(1'b0, 1'b1, REG_STATUS);
        br_w   = 1'b1;
        #1;
        d  = bd_out;
        oe = bd_oe;
        bus_idle();
    endtask

    task automatic check_status(input string what, input logic [7:0] exp);
        logic [7:0] d;
        logic       oe;
        read_status(d, oe);
        check({what, " oe"}, {31'd0, oe}, 32'd1);
        check(what, {24'd0, d}, {24'd0, exp});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Caller sits #1 after the edge preceding bit-clock first_k of the frame.
    task automatic expect_frame(input logic [7:0] b, input int first_k);
        logic [10:0] f;
        f = make_frame(b);
        for (int k = first_k; k < 11 * DIV; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("sd_wr byte %0h clk %0d", b, k), {31'd0, sd_wr}, {31'd0, f[k/DIV]});
            if (tx_busy) busy_cnt++;
            if (k % DIV == 2) rx[k/DIV] = sd_wr;
        end
    endtask

    initial begin
        logic [10:0] fa;
        logic [7:0]  d;
        logic        oe;

        dv[0] = '{1'b0, addr(1'b1, 1'b1, REG_DATA),   1'b0, 8'h5A, 1'b0, 8'h00};
        dv[1] = '{1'b1, addr(1'b0, 1'b1, REG_DATA),   1'b0, 8'h5A, 1'b0, 8'h00};
        dv[2] = '{1'b0, addr(1'b0, 1'b1, REG_DATA),   1'b1, 8'h5A, 1'b0, 8'h00};
        dv[3] = '{1'b0, addr(1'b0, 1'b0, REG_STATUS), 1'b1, 8'h00, 1'b0, 8'h00};
        dv[4] = '{1'b0, addr(1'b0, 1'b1, REG_STATUS), 1'b1, 8'h00, 1'b1, 8'h00};
        dv[5] = '{1'b0, addr(1'b0, 1'b1, REG_CTRL),   1'b0, 8'h04, 1'b0, 8'h04};
        dv[6] = '{1'b0, addr(1'b0, 1'b1, REG_DATA),   1'b0, 8'h5A, 1'b0, 8'h06};

        fa = make_frame(8'hA5);
        rst_n = 1'b1;
        bus_idle();
        #1;
        rst_n = 1'b0;
        #1;
        check("reset sd_wr", {31'd0, sd_wr}, 32'd1);
        check("reset tx_busy", {31'd0, tx_busy}, 32'd0);
        check("reset irq_n", {31'd0, irq_n}, 32'd1);
        check("reset bd_oe", {31'd0, bd_oe}, 32'd0);
        check("reset bd_out", {24'd0, bd_out}, 32'd0);
        do_reset();
        check_status("reset status", 8'h00);

        // Decode table
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            sser_n = dv[i].sser_n;
            ba     = dv[i].ba;
            br_w   = dv[i].br_w;
            bd_in  = dv[i].bd;
            #1;
            check($sformatf("decode %0d bd_oe", i), {31'd0, bd_oe}, {31'd0, dv[i].exp_oe});
            @(posedge clk);
            #1;
            bus_idle();
            check_status($sformatf("decode %0d status", i), dv[i].exp_stat);
        end

        // Single frame of A5 with interrupt enabled
        do_reset();
        bus_write(REG_CTRL, 8'h04);
        check("irq_n empty", {31'd0, irq_n}, 32'd0);
        bus_write(REG_DATA, 8'hA5);
        check("irq_n full", {31'd0, irq_n}, 32'd1);
        check_status("a5 status full", 8'h06);
        @(posedge clk);
        #1;
        check("a5 pre-start sd_wr", {31'd0, sd_wr}, 32'd1);
        check("a5 load irq_n", {31'd0, irq_n}, 32'd0);
        busy_cnt = tx_busy ? 1 : 0;
        expect_frame(8'hA5, 0);
        check("a5 busy clks", busy_cnt, 32'd44);
        check("a5 data bits", {24'd0, rx[8:1]}, {24'd0, fa[8:1]});

        // Back-to-back, simultaneous drain and write, overrun and its clear
        do_reset();
        bus_write(REG_DATA, 8'h01);
        bus_write(REG_DATA, 8'hFF);
        check_status("b2b capture on drain", 8'h03);
        bus_write(REG_DATA, 8'h55);
        check_status("b2b overrun", 8'h0B);
        check("b2b start bit", {31'd0, sd_wr}, 32'd0);
        expect_frame(8'h01, 1);
        expect_frame(8'hFF, 0);
        check_status("b2b after frames", 8'h08);
        bus_write(REG_CTRL, 8'h01);
        check_status("overrun cleared", 8'h00);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("b2b no third frame", {30'd0, sd_wr, tx_busy}, 32'd2);
        end

        // Abort mid-DATA
        do_reset();
        bus_write(REG_DATA, 8'hA5);
        repeat (11) @(posedge clk);
        #1;
        check("abort pre sd_wr", {31'd0, sd_wr}, {31'd0, fa[2]});
        bus_write(REG_CTRL, 8'h02);
        check("abort sd_wr", {31'd0, sd_wr}, 32'd1);
        check("abort tx_busy", {31'd0, tx_busy}, 32'd0);
        check_status("abort status", 8'h00);
        repeat (8) begin
            @(posedge clk);
            #1;
            check("abort stays idle", {30'd0, sd_wr, tx_busy}, 32'd2);
        end

        // Async reset mid-PARITY
        do_reset();
        bus_write(REG_CTRL, 8'h04);
        bus_write(REG_DATA, 8'hA5);
        repeat (39) @(posedge clk);
        #1;
        check("parity bit", {31'd0, sd_wr}, {31'd0, fa[9]});
        check("mid-frame irq_n", {31'd0, irq_n}, 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        check("async rst sd_wr", {31'd0, sd_wr}, 32'd1);
        check("async rst tx_busy", {31'd0, tx_busy}, 32'd0);
        check("async rst irq_n", {31'd0, irq_n}, 32'd1);
        read_status(d, oe);
        check("async rst status", {23'd0, oe, d}, 32'h100);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
            check("post rst idle", {30'd0, sd_wr, tx_busy}, 32'd2);
        end

`ifdef CLE_SCRAMBLE_EN
        // Scrambled all-zero byte: data bits are the LFSR tap sequence
        begin
            logic [6:1] m;
            logic [7:0] dec;
            logic       tap;
            do_reset();
            bus_write(REG_DATA, 8'h00);
            @(posedge clk);
            #1;
            expect_frame(8'h00, 0);
            m = SEED;
            for (int i = 0; i < 8; i++) begin
                tap = m[1] ^ m[4] ^ m[6];
                dec[i] = rx[1+i] ^ tap;
                m = {m[5:1], tap};
            end
            check("descrambled byte", {24'd0, dec}, 32'd0);
            check("scrambled parity", {31'd0, ^rx[9:1]}, 32'd0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
